// File: rtl/johnson_dec_pkg.sv
// Johnson decoder shared types: FSM states and the code-to-index table.
// Optional error counter is enabled by JOHNSON_DEC_ERRCNT_EN.
package johnson_dec_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // entry i is the Johnson code whose index is i
  localparam logic [7:0][3:0] CODE_TAB = {
    4'b0001, 4'b0011, 4'b0111, 4'b1111,
    4'b1110, 4'b1100, 4'b1000, 4'b0000
  };

  // {legal, idx} returned for any code not in CODE_TAB
  localparam logic [3:0] LUT_ILLEGAL = 4'b0000;

endpackage

// File: rtl/johnson_code_lut.sv
// Combinational Johnson code -> {legal, idx} lookup.
// Shares CODE_TAB with the rest of the johnson_dec slice.
module johnson_code_lut
  import johnson_dec_pkg::*;
(
  input  logic [3:0] code,
  output logic       legal,
  output logic [2:0] idx
);

  always_comb begin
    {legal, idx} = LUT_ILLEGAL;
    for (int i = 0; i < 8; i++) begin
      if (code == CODE_TAB[i]) begin
        {legal, idx} = {1'b1, 3'(i)};
      end
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter decoder with successor checking and lock FSM.
// Define JOHNSON_DEC_ERRCNT_EN to add the saturating ERR_CNT output.
module johnson_decoder #(
  parameter int LOCK_CNT  = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       EN,
  input  logic [3:0] Q,
  input  logic       CLR_ERR,
  output logic [2:0] IDX,
  output logic [7:0] ONEHOT,
  output logic       VALID,
  output logic       LOCKED,
  output logic       ERR_CODE,
  output logic       ERR_SEQ,
  output logic       ERR_STICKY
`ifdef JOHNSON_DEC_ERRCNT_EN
 ,output logic [ERR_CNT_W-1:0] ERR_CNT
`endif
);

  import johnson_dec_pkg::*;

  state_t     st_q, st_d;
  logic [2:0] run_q, run_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       ec_q, ec_d;
  logic       es_q, es_d;
  logic       sticky_q, sticky_d;
  logic       lut_legal;
  logic [2:0] lut_idx;
  logic       succ;
  logic       err_now;

  johnson_code_lut u_lut (
    .code  (Q),
    .legal (lut_legal),
    .idx   (lut_idx)
  );

  // successor only counts when the previous sample was itself legal
  assign succ    = valid_q && (lut_idx == 3'(idx_q + 3'd1));
  assign err_now = ec_d | es_d;

  always_comb begin
    st_d    = st_q;
    run_d   = run_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ec_d    = 1'b0;
    es_d    = 1'b0;
    if (EN) begin
      valid_d = lut_legal;
      if (lut_legal) idx_d = lut_idx;
      unique case (st_q)
        johnson_dec_pkg::HUNT: begin
          if (!lut_legal) begin
            ec_d  = 1'b1;
            run_d = '0;
          end else if (!succ) begin
            run_d = '0;
          end else if (int'(run_q) + 1 >= LOCK_CNT) begin
            st_d  = johnson_dec_pkg::LOCKED;
            run_d = '0;
          end else begin
            run_d = run_q + 3'd1;
          end
        end
        johnson_dec_pkg::LOCKED: begin
          if (!lut_legal) begin
            ec_d  = 1'b1;
            st_d  = johnson_dec_pkg::HUNT;
            run_d = '0;
          end else if (!succ) begin
            es_d  = 1'b1;
            st_d  = johnson_dec_pkg::HUNT;
            run_d = '0;
          end
        end
        default: st_d = johnson_dec_pkg::HUNT;
      endcase
    end
    // clear first, then this sample's error
    sticky_d = (CLR_ERR ? 1'b0 : sticky_q) | err_now;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      st_q     <= johnson_dec_pkg::HUNT;
      run_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      ec_q     <= 1'b0;
      es_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      run_q    <= run_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      ec_q     <= ec_d;
      es_q     <= es_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = CLR_ERR ? '0 : cnt_q;
    if (err_now && (cnt_d != '1)) begin
      cnt_d = cnt_d + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign ERR_CNT = cnt_q;
`endif

  assign IDX        = idx_q;
  assign VALID      = valid_q;
  assign ONEHOT     = valid_q ? (8'd1 << idx_q) : 8'd0;
  assign LOCKED     = (st_q == johnson_dec_pkg::LOCKED);
  assign ERR_CODE   = ec_q;
  assign ERR_SEQ    = es_q;
  assign ERR_STICKY = sticky_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (LOCK_CNT=3, ERR_CNT_W=8).
// ERR_CNT checks are compiled in only with JOHNSON_DEC_ERRCNT_EN.
module tb_johnson_decoder;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       EN = 1'b0;
  logic [3:0] Q = 4'b0000;
  logic       CLR_ERR = 1'b0;
  logic [2:0] IDX;
  logic [7:0] ONEHOT;
  logic       VALID;
  logic       LOCKED;
  logic       ERR_CODE;
  logic       ERR_SEQ;
  logic       ERR_STICKY;
`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [7:0] ERR_CNT;
`endif

  int nvec = 0;
  int nmis = 0;

  logic [3:0] codes [8] = '{
    4'b0000, 4'b1000, 4'b1100, 4'b1110,
    4'b1111, 4'b0111, 4'b0011, 4'b0001
  };

  johnson_decoder #(
    .LOCK_CNT  (3),
    .ERR_CNT_W (8)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .EN         (EN),
    .Q          (Q),
    .CLR_ERR    (CLR_ERR),
    .IDX        (IDX),
    .ONEHOT     (ONEHOT),
    .VALID      (VALID),
    .LOCKED     (LOCKED),
    .ERR_CODE   (ERR_CODE),
    .ERR_SEQ    (ERR_SEQ),
    .ERR_STICKY (ERR_STICKY)
`ifdef JOHNSON_DEC_ERRCNT_EN
   ,.ERR_CNT    (ERR_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef JOHNSON_DEC_ERRCNT_EN
    chk(tag, 32'(ERR_CNT), 32'(exp));
`endif
  endtask

  // drive on the falling edge, look #1 after the rising edge
  task automatic step(input logic [3:0] q,
                      input logic en,
                      input logic ce);
    @(negedge CLK);
    Q = q;
    EN = en;
    CLR_ERR = ce;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string tag,
                            input logic [2:0] idx,
                            input logic valid,
                            input logic locked,
                            input logic ec,
                            input logic es,
                            input logic sticky);
    logic [7:0] oh;
    oh = valid ? (8'd1 << idx) : 8'd0;
    chk({tag, ".idx"}, 32'(IDX), 32'(idx));
    chk({tag, ".onehot"}, 32'(ONEHOT), 32'(oh));
    chk({tag, ".valid"}, 32'(VALID), 32'(valid));
    chk({tag, ".locked"}, 32'(LOCKED), 32'(locked));
    chk({tag, ".err_code"}, 32'(ERR_CODE), 32'(ec));
    chk({tag, ".err_seq"}, 32'(ERR_SEQ), 32'(es));
    chk({tag, ".sticky"}, 32'(ERR_STICKY), 32'(sticky));
  endtask

  initial begin
    #12;
    expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("reset.cnt", 0);
    @(negedge CLK);
    CLR = 1'b1;

    // free-running counter: lock after 3rd successor, wrap 7->0
    for (int i = 0; i < 16; i++) begin
      step(codes[i % 8], 1'b1, 1'b0);
      expect_out($sformatf("run%0d", i), 3'(i % 8), 1'b1,
                 (i >= 3), 1'b0, 1'b0, 1'b0);
    end
    chk_cnt("run.cnt", 0);

    // locked at idx 3, then an illegal code
    for (int i = 0; i < 4; i++) step(codes[i], 1'b1, 1'b0);
    chk("pre_ill.locked", 32'(LOCKED), 32'd1);
    step(4'b1010, 1'b1, 1'b0);
    expect_out("ill", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_cnt("ill.cnt", 1);
    step(4'b1111, 1'b1, 1'b0);
    expect_out("ill_after", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // relock (5,6,7), walk to idx 2, then jump to idx 4
    step(codes[5], 1'b1, 1'b0);
    step(codes[6], 1'b1, 1'b0);
    step(codes[7], 1'b1, 1'b0);
    chk("relock.locked", 32'(LOCKED), 32'd1);
    for (int i = 0; i < 3; i++) step(codes[i], 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    expect_out("jump", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_cnt("jump.cnt", 2);

    // repeated code while hunting: restart only
    step(4'b1100, 1'b1, 1'b0);
    expect_out("hunt_a", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b1100, 1'b1, 1'b0);
    expect_out("hunt_b", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // repeated code while locked: sequence error
    step(codes[3], 1'b1, 1'b0);
    step(codes[4], 1'b1, 1'b0);
    step(codes[5], 1'b1, 1'b0);
    chk("stall_pre.locked", 32'(LOCKED), 32'd1);
    step(codes[5], 1'b1, 1'b0);
    expect_out("stall", 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_cnt("stall.cnt", 3);

    // clear with no new error
    step(codes[6], 1'b1, 1'b1);
    expect_out("clr", 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("clr.cnt", 0);

    // 300 illegal samples: counter saturates
    for (int k = 0; k < 300; k++) begin
      step(4'b1010, 1'b1, 1'b0);
      if (k == 254) chk_cnt("sat255", 255);
    end
    expect_out("sat", 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_cnt("sat.cnt", 255);
    step(4'b0110, 1'b1, 1'b1);
    expect_out("clr_err", 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_cnt("clr_err.cnt", 1);

    // lock at idx 3, then hold with EN low
    for (int i = 0; i < 4; i++) step(codes[i], 1'b1, 1'b0);
    expect_out("lk3", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'b1010, 1'b0, 1'b0);
    expect_out("en0_a", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    expect_out("en0_e", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_cnt("en0.cnt", 1);
    step(4'b1111, 1'b1, 1'b0);
    expect_out("en1", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // async reset between edges
    #2;
    CLR = 1'b0;
    #1;
    expect_out("areset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("areset.cnt", 0);
    @(negedge CLK);
    CLR = 1'b1;
    step(codes[0], 1'b1, 1'b0);
    step(codes[1], 1'b1, 1'b0);
    step(codes[2], 1'b1, 1'b0);
    expect_out("post_a", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(codes[3], 1'b1, 1'b0);
    expect_out("post_b", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
